// File: rtl/tt_um_down_timer.sv
// Loadable down-counting timer on the Tiny Tapeout user pins: load a start value,
// run it down to zero, emit a one-cycle done pulse, then stop or auto-reload.
module tt_um_down_timer #(
  parameter int unsigned WIDTH       = 4,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] ui_in,
  output logic [3:0] uo_out,
  input  logic [3:0] uio_in,
  output logic [3:0] uio_out,
  output logic [3:0] uio_oe,
  input  logic       ena
);

  typedef enum logic [1:0] {IDLE, RUN, RELOAD, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             done_q;
  logic             busy_q;

  logic             load_i;
  logic             run_i;
  logic [WIDTH-1:0] load_val;
  logic             unused_ok;

  assign load_i    = uio_in[0];
  assign run_i     = uio_in[1];
  assign load_val  = WIDTH'(ui_in);
  assign unused_ok = &{1'b0, ena, uio_in[3:2]};

  assign uo_out  = 4'(count_q);
  assign uio_out = {done_q, busy_q, 2'b00};
  assign uio_oe  = 4'b1100;

  // busy is registered alongside the state so it always matches the state being entered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load_i) begin
        count_q  <= load_val;
        reload_q <= load_val;
        state_q  <= IDLE;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (run_i) begin
              if (count_q != '0) begin
                state_q <= RUN;
                busy_q  <= 1'b1;
              end else begin
                state_q <= DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
          RUN: begin
            if (run_i) begin
              if (count_q == WIDTH'(1)) begin
                count_q <= '0;
                done_q  <= 1'b1;
                if (AUTO_RELOAD && (reload_q != '0)) begin
                  state_q <= RELOAD;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                end
              end else if (count_q != '0) begin
                count_q <= count_q - WIDTH'(1);
              end
            end
          end
          RELOAD: begin
            count_q <= reload_q;
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
          DONE: begin
            count_q <= '0;
            busy_q  <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
